// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store front end.
// FSM state encoding and RISC-V load/store funct3 codes.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      LOAD_WAIT,
      RMW_WAIT,
      RESP,
      ERR_RESP
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle of the load/store front end.
// The core is the master; mem_access_unit is the slave.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_funct3,
      output req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_funct3,
      input  req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );

endinterface

// File: rtl/mem_lane_format.sv
// Byte-lane handling: load extraction/extension and SB/SH merge.
// Assumes the request already passed the alignment check.
module mem_lane_format
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [4:0]  shift;
   logic [31:0] lane;
   logic [31:0] mask;

   assign shift = {offset, 3'b000};
   assign lane  = old_word >> shift;

   always_comb begin
      unique case (1'b1)
         (funct3[1:0] == 2'b00): mask = 32'h0000_00ff;
         (funct3[1:0] == 2'b01): mask = 32'h0000_ffff;
         default:                mask = 32'hffff_ffff;
      endcase
   end

   always_comb begin
      load_data = lane;
      case (funct3)
         F3_B:  load_data = {{24{lane[7]}}, lane[7:0]};
         F3_BU: load_data = {24'h0, lane[7:0]};
         F3_H:  load_data = {{16{lane[15]}}, lane[15:0]};
         F3_HU: load_data = {16'h0, lane[15:0]};
         default: load_data = lane;
      endcase
   end

   assign merged_word = (old_word & ~(mask << shift))
                      | ((store_data & mask) << shift);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only block_memory.
// Checks requests, does RMW for SB/SH, extends load data.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_access_unit_if.slave      bus,
   output logic                  mem_enabled,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  write_enable,
   output logic [31:0]           write_data,
   input  logic [31:0]           read_data
);

   state_t               state;
   logic                 write_q;
   logic [2:0]           funct3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]          wdata_q;

   logic                 misaligned;
   logic                 out_of_range;
   logic                 illegal;
   logic                 req_err;
   logic                 is_sw;
   logic [31:0]          load_data;
   logic [31:0]          merged_word;

   always_comb begin
      misaligned = 1'b0;
      if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU)
          && bus.req_addr[0])
         misaligned = 1'b1;
      if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)
         misaligned = 1'b1;
   end

   assign out_of_range = |bus.req_addr[31:ADDR_WIDTH+2];

   always_comb begin
      if (bus.req_write)
         illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(bus.req_funct3 inside
                     {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   end

   assign req_err = misaligned || out_of_range || illegal;
   assign is_sw   = write_q && (funct3_q == F3_W);

   mem_lane_format lane_fmt (
      .funct3      (funct3_q),
      .offset      (addr_q[1:0]),
      .old_word    (read_data),
      .store_data  (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Gated by rst so a reset cycle never touches memory.
   assign mem_enabled  = !rst
                       && (state == ACCESS || state == RMW_WAIT);
   assign write_enable = !rst
                       && ((state == ACCESS && is_sw)
                           || state == RMW_WAIT);
   assign write_data   = (state == RMW_WAIT) ? merged_word : wdata_q;
   assign address      = addr_q[ADDR_WIDTH+1:2];
   assign bus.req_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         write_q        <= 1'b0;
         funct3_q       <= 3'b000;
         addr_q         <= '0;
         wdata_q        <= 32'h0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= 32'h0;
         bus.resp_error <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q  <= bus.req_write;
                  funct3_q <= bus.req_funct3;
                  addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
                  wdata_q  <= bus.req_wdata;
                  if (req_err) begin
                     state          <= ERR_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_error <= 1'b1;
                     bus.resp_rdata <= 32'h0;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!write_q) begin
                  state <= LOAD_WAIT;
               end else if (is_sw) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_error <= 1'b0;
                  bus.resp_rdata <= 32'h0;
               end else begin
                  state <= RMW_WAIT;
               end
            end
            LOAD_WAIT: begin
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               bus.resp_error <= 1'b0;
               bus.resp_rdata <= load_data;
            end
            RMW_WAIT: begin
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               bus.resp_error <= 1'b0;
               bus.resp_rdata <= 32'h0;
            end
            RESP, ERR_RESP: state <= IDLE;
            default:        state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a block_memory model.
// Expected values are hand-computed constants.
module tb_mem_access_unit;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_enabled;
   logic [AW-1:0] address;
   logic          write_enable;
   logic [31:0]   write_data;
   logic [31:0]   read_data;

   mem_access_unit_if bus ();

   mem_access_unit #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .mem_enabled  (mem_enabled),
      .address      (address),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (mem_enabled) begin
         if (write_enable) mem[address] <= write_data;
         read_data <= mem[address];
      end
   end

   int en_cnt = 0;
   int we_cnt = 0;
   int resp_cnt = 0;
   logic [31:0] we_last = 32'h0;

   always @(posedge clk) begin
      if (mem_enabled) en_cnt++;
      if (write_enable) begin
         we_cnt++;
         we_last = write_data;
      end
      if (bus.resp_valid) resp_cnt++;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h",
                    tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [AW-1:0] cap_addr;
   logic          cap_we;
   logic [31:0]   cap_wd;
   int            en_start;
   int            we_start;

   task automatic do_req(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat);
      int g;
      g = 0;
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      while (!bus.req_ready && g < 20) begin
         step();
         g++;
      end
      en_start = en_cnt;
      we_start = we_cnt;
      step();
      bus.req_valid = 1'b0;
      cap_addr = address;
      cap_we   = write_enable;
      cap_wd   = write_data;
      lat = 1;
      while (!bus.resp_valid && lat < 10) begin
         step();
         lat++;
      end
      chk("resp_seen", {31'h0, bus.resp_valid}, 32'h1);
      rd = bus.resp_rdata;
      er = bus.resp_error;
      step();
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          r0;
   int          w0;

   task automatic load_chk(input string tag, input logic [2:0] f3,
                           input logic [31:0] a,
                           input logic [31:0] exp);
      do_req(1'b0, f3, a, 32'h0, rd, er, lat);
      chk(tag, rd, exp);
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_err"}, {31'h0, er}, 32'h0);
   endtask

   task automatic err_chk(input string tag, input logic w,
                          input logic [2:0] f3,
                          input logic [31:0] a);
      do_req(w, f3, a, 32'h1234_5678, rd, er, lat);
      chk({tag, "_err"}, {31'h0, er}, 32'h1);
      chk({tag, "_rdata"}, rd, 32'h0);
      chk({tag, "_lat"}, lat, 1);
      chk({tag, "_en"}, en_cnt - en_start, 0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      step();
      step();
      chk("rst_en", {31'h0, mem_enabled}, 32'h0);
      chk("rst_we", {31'h0, write_enable}, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rst_rv", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_rerr", {31'h0, bus.resp_error}, 32'h0);

      do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, rd, er, lat);
      chk("sw_addr", {22'h0, cap_addr}, 32'h2);
      chk("sw_we", {31'h0, cap_we}, 32'h1);
      chk("sw_wd", cap_wd, 32'hDEAD_BEEF);
      chk("sw_lat", lat, 2);
      chk("sw_err", {31'h0, er}, 32'h0);
      load_chk("lw8", 3'b010, 32'h8, 32'hDEAD_BEEF);

      do_req(1'b1, 3'b010, 32'h0, 32'h1122_3344, rd, er, lat);
      do_req(1'b1, 3'b000, 32'h2, 32'h0000_00AB, rd, er, lat);
      chk("sb_lat", lat, 3);
      chk("sb_wcnt", we_cnt - we_start, 1);
      chk("sb_wd", we_last, 32'h11AB_3344);
      chk("sb_rdata", rd, 32'h0);
      load_chk("lw0_sb", 3'b010, 32'h0, 32'h11AB_3344);

      do_req(1'b1, 3'b001, 32'hA, 32'h5555_CAFE, rd, er, lat);
      chk("sh_wd", we_last, 32'hCAFE_BEEF);
      load_chk("lw8_sh", 3'b010, 32'h8, 32'hCAFE_BEEF);
      load_chk("lb_b", 3'b000, 32'hB, 32'hFFFF_FFCA);

      do_req(1'b1, 3'b010, 32'h4, 32'h8000_FF80, rd, er, lat);
      load_chk("lb4", 3'b000, 32'h4, 32'hFFFF_FF80);
      load_chk("lbu4", 3'b100, 32'h4, 32'h0000_0080);
      load_chk("lbu5", 3'b100, 32'h5, 32'h0000_00FF);
      load_chk("lh6", 3'b001, 32'h6, 32'hFFFF_8000);
      load_chk("lhu6", 3'b101, 32'h6, 32'h0000_8000);
      load_chk("lh4", 3'b001, 32'h4, 32'hFFFF_FF80);

      err_chk("lw6", 1'b0, 3'b010, 32'h6);
      err_chk("sh3", 1'b1, 3'b001, 32'h3);
      err_chk("lw_oor", 1'b0, 3'b010, 32'h1000);
      err_chk("ld_f3", 1'b0, 3'b011, 32'h0);
      err_chk("st_f3", 1'b1, 3'b100, 32'h0);

      do_req(1'b1, 3'b010, 32'h0, 32'hAAAA_AAAA, rd, er, lat);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0000_1234;
      r0 = resp_cnt;
      w0 = we_cnt;
      step();
      bus.req_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("mr_we", {31'h0, write_enable}, 32'h0);
      chk("mr_en", {31'h0, mem_enabled}, 32'h0);
      step();
      rst = 1'b0;
      #1;
      chk("mr_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("mr_rv", {31'h0, bus.resp_valid}, 32'h0);
      chk("mr_wcnt", we_cnt - w0, 0);
      chk("mr_rcnt", resp_cnt - r0, 0);
      load_chk("lw0_mr", 3'b010, 32'h0, 32'hAAAA_AAAA);

      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h8;
      bus.req_wdata  = 32'h0;
      chk("hs_rdy0", {31'h0, bus.req_ready}, 32'h1);
      step();
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h4;
      chk("hs_rdy1", {31'h0, bus.req_ready}, 32'h0);
      step();
      chk("hs_rdy2", {31'h0, bus.req_ready}, 32'h0);
      step();
      chk("hs_rdy3", {31'h0, bus.req_ready}, 32'h0);
      chk("hs_rv1", {31'h0, bus.resp_valid}, 32'h1);
      chk("hs_rd1", bus.resp_rdata, 32'hCAFE_BEEF);
      step();
      chk("hs_rdy4", {31'h0, bus.req_ready}, 32'h1);
      chk("hs_rv_off", {31'h0, bus.resp_valid}, 32'h0);
      step();
      bus.req_valid = 1'b0;
      chk("hs_rdy5", {31'h0, bus.req_ready}, 32'h0);
      step();
      chk("hs_rv6", {31'h0, bus.resp_valid}, 32'h0);
      step();
      chk("hs_rv2", {31'h0, bus.resp_valid}, 32'h1);
      chk("hs_rd2", bus.resp_rdata, 32'hFFFF_FF80);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
